// File: rtl/memory_stage_pkg.sv
// Shared constants for the MEM pipeline stage: pass-bundle bit positions,
// writeback-select encodings and the memory access FSM states.
package memory_stage_pkg;

  localparam int PASS_ST       = 0;
  localparam int PASS_LD       = 1;
  localparam int PASS_HALT     = 2;
  localparam int PASS_WBSEL_LO = 3;
  localparam int PASS_WBSEL_HI = 4;
  localparam int PASS_REGW     = 5;
  localparam int PASS_DST_LO   = 6;
  localparam int PASS_DST_HI   = 8;

  typedef enum logic [1:0] {
    WB_PC2 = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10,
    WB_ALU = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/memory_stage_dff.sv
// Enabled register with synchronous active-low reset to zero; used for the
// MEM/WB register bank.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] reg_q;
  logic [W-1:0] reg_d;

  // hold unless enabled
  always_comb begin
    reg_d = reg_q;
    if (en) begin
      reg_d = d;
    end else begin
      reg_d = reg_q;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q = reg_q;

endmodule

// File: rtl/memory_stage_mem_access_fsm.sv
// Memory access sequencer: request/stall handshake, wait-cycle timeout
// counter and the absorbing HALTED state.
module mem_access_fsm
  import memory_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic mem_op,
  input  logic halt_op,
  input  logic mem_done,
  output logic mem_req,
  output logic stall_mem,
  output logic retire,
  output logic timeout,
  output logic halted
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit TIMEOUT_EN = (MAX_WAIT > 0);
  // with no timeout the counter simply parks at all-ones
  localparam logic [CW-1:0] CNT_MAX = (MAX_WAIT > 0) ? CW'(MAX_WAIT) : {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_s, stall_s, retire_s, timeout_s;

  // next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_s     = 1'b0;
    stall_s   = 1'b0;
    retire_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          req_s = 1'b1;
          if (mem_done) begin
            retire_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            state_d = WAIT;
            cnt_d   = CNT_ONE;
          end
        end else if (in_valid) begin
          retire_s = 1'b1;
          state_d  = halt_op ? HALTED : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        req_s = 1'b1;
        if (mem_done) begin
          retire_s = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (TIMEOUT_EN && (cnt_q >= CNT_MAX)) begin
          retire_s  = 1'b1;
          timeout_s = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          stall_s = 1'b1;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // nothing is requested or retired while held in reset
  assign mem_req   = rst & req_s;
  assign stall_mem = rst & stall_s;
  assign retire    = rst & retire_s;
  assign timeout   = rst & timeout_s;
  assign halted    = (state_q == HALTED);

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: data memory handshake, writeback select and MEM/WB
// registers. Optional MEM_ALIGN_CHK_EN rejects odd addresses on memory ops.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DW       = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] addr_em,
  input  logic [DW-1:0] data_em,
  input  logic [8:0]    pass_em,
  input  logic [DW-1:0] imme_em,
  input  logic [DW-1:0] pc2_em,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          stall_mem,
  output logic [DW-1:0] wb_data,
  output logic [2:0]    wb_reg,
  output logic          wb_en,
  output logic          wb_halt,
  output logic          wb_err
);

  logic       st_s, ld_s, halt_s, regw_s;
  logic [1:0] wb_sel_s;
  logic [2:0] dst_s;
  logic       access_s, misalign_s, mem_op_s, err_s;
  logic       retire_s, timeout_s, halted_s;

  assign st_s     = pass_em[PASS_ST];
  assign ld_s     = pass_em[PASS_LD];
  assign halt_s   = pass_em[PASS_HALT];
  assign regw_s   = pass_em[PASS_REGW];
  assign wb_sel_s = pass_em[PASS_WBSEL_HI:PASS_WBSEL_LO];
  assign dst_s    = pass_em[PASS_DST_HI:PASS_DST_LO];

  // halts never touch memory, and St+Ld together is malformed
  assign access_s = in_valid & (st_s ^ ld_s) & ~halt_s;
`ifdef MEM_ALIGN_CHK_EN
  assign misalign_s = access_s & addr_em[0];
`else
  assign misalign_s = 1'b0;
`endif
  assign mem_op_s = access_s & ~misalign_s;
  assign err_s    = (st_s & ld_s) | timeout_s | misalign_s;

  mem_access_fsm #(
    .MAX_WAIT(MAX_WAIT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .mem_op   (mem_op_s),
    .halt_op  (in_valid & halt_s),
    .mem_done (mem_done),
    .mem_req  (mem_req),
    .stall_mem(stall_mem),
    .retire   (retire_s),
    .timeout  (timeout_s),
    .halted   (halted_s)
  );

  assign mem_wr    = mem_req & st_s;
  assign mem_addr  = addr_em;
  assign mem_wdata = data_em;

  logic [DW-1:0] wb_data_d;
  logic [2:0]    wb_flags_d, wb_flags_q;

  // writeback data select
  always_comb begin
    wb_data_d = pc2_em;
    case (wb_sel_s)
      WB_PC2:  wb_data_d = pc2_em;
      WB_MEM:  wb_data_d = ld_s ? mem_rdata : {DW{1'b0}};
      WB_IMM:  wb_data_d = imme_em;
      WB_ALU:  wb_data_d = addr_em;
      default: wb_data_d = pc2_em;
    endcase
  end

  assign wb_flags_d = {retire_s & regw_s & ~st_s & ~err_s,
                       halted_s | (retire_s & halt_s),
                       retire_s & err_s};

  dff #(.W(DW)) u_wb_data (
    .clk(clk), .rst(rst), .en(retire_s), .d(wb_data_d), .q(wb_data)
  );

  dff #(.W(3)) u_wb_reg (
    .clk(clk), .rst(rst), .en(retire_s), .d(dst_s), .q(wb_reg)
  );

  dff #(.W(3)) u_wb_flags (
    .clk(clk), .rst(rst), .en(1'b1), .d(wb_flags_d), .q(wb_flags_q)
  );

  assign wb_en   = wb_flags_q[2];
  assign wb_halt = wb_flags_q[1];
  assign wb_err  = wb_flags_q[0];

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a cycle-level behavioural model checked on
// every negedge, plus hand-computed literal expectations per scenario.
`timescale 1ns/1ps
module tb_memory_stage;

  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] addr_em = '0, data_em = '0, imme_em = '0, pc2_em = '0;
  logic [8:0]    pass_em = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_done = 1'b0;
  logic          mem_req, mem_wr, stall_mem;
  logic [DW-1:0] mem_addr, mem_wdata, wb_data;
  logic [2:0]    wb_reg;
  logic          wb_en, wb_halt, wb_err;

  always #5 clk = ~clk;

  memory_stage #(.DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .addr_em(addr_em),
    .data_em(data_em), .pass_em(pass_em), .imme_em(imme_em), .pc2_em(pc2_em),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_mem(stall_mem), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_en(wb_en), .wb_halt(wb_halt), .wb_err(wb_err)
  );

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] mkpass(input logic st, input logic ld, input logic hl,
                                        input logic [1:0] sel, input logic regw,
                                        input logic [2:0] dst);
    return {dst, regw, sel, hl, ld, st};
  endfunction

  // behavioural model state: age = cycles the current bundle has been stalled
  logic          m_ok = 1'b0;
  logic          m_halted;
  int            m_age;
  logic [DW-1:0] e_data;
  logic [2:0]    e_reg;
  logic          e_en, e_halt, e_err;
  logic          n_halted;
  int            n_age;
  logic [DW-1:0] n_data;
  logic [2:0]    n_reg;
  logic          n_en, n_halt, n_err;

  always @(negedge clk) begin : compare
    logic st, ld, hl, regw, acc, mis, op, to, ret, err, ereq, estall;
    logic [1:0] sel;
    logic [DW-1:0] wd;
    st = pass_em[0]; ld = pass_em[1]; hl = pass_em[2];
    sel = pass_em[4:3]; regw = pass_em[5];
    acc = in_valid & (st ^ ld) & ~hl & ~m_halted;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    mis = acc & addr_em[0];
`endif
    op = acc & ~mis;
    to = op & ~mem_done & (m_age == MW);
    ereq = rst & op;
    estall = rst & op & ~mem_done & ~to;
    ret = rst & ~m_halted & in_valid & (~op | mem_done | to);
    err = (st & ld) | to | mis;
    case (sel)
      2'd0: wd = pc2_em;
      2'd1: wd = ld ? mem_rdata : 16'h0000;
      2'd2: wd = imme_em;
      default: wd = addr_em;
    endcase
    if (m_ok) begin
      chk("mem_req", mem_req, ereq);
      chk("mem_wr", mem_wr, ereq & st);
      chk("stall_mem", stall_mem, estall);
      if (ereq) begin
        chk("mem_addr", mem_addr, addr_em);
        chk("mem_wdata", mem_wdata, data_em);
      end
      chk("wb_data", wb_data, e_data);
      chk("wb_reg", wb_reg, e_reg);
      chk("wb_en", wb_en, e_en);
      chk("wb_halt", wb_halt, e_halt);
      chk("wb_err", wb_err, e_err);
    end
    n_halted = m_halted | (ret & hl);
    n_age    = estall ? m_age + 1 : 0;
    n_data   = ret ? wd : e_data;
    n_reg    = ret ? pass_em[8:6] : e_reg;
    n_en     = ret & regw & ~st & ~err;
    n_err    = ret & err;
    n_halt   = n_halted;
  end

  always @(posedge clk) begin : model_update
    if (!rst) begin
      m_ok <= 1'b1; m_halted <= 1'b0; m_age <= 0;
      e_data <= '0; e_reg <= '0; e_en <= 1'b0; e_halt <= 1'b0; e_err <= 1'b0;
    end else begin
      m_halted <= n_halted; m_age <= n_age;
      e_data <= n_data; e_reg <= n_reg; e_en <= n_en; e_halt <= n_halt; e_err <= n_err;
    end
  end

  logic s_req, s_stall;

  task automatic put(input logic v, input logic [8:0] p, input logic [DW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] im,
                     input logic [DW-1:0] pc, input logic dn, input logic [DW-1:0] rd);
    in_valid = v; pass_em = p; addr_em = a; data_em = d;
    imme_em = im; pc2_em = pc; mem_done = dn; mem_rdata = rd;
  endtask

  task automatic idle();
    put(1'b0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic tick();
    @(negedge clk);
    s_req = mem_req;
    s_stall = stall_mem;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_req, n_st;
    idle();
    rst = 1'b0;
    tick(); tick();
    chk("rst_req", s_req, 1'b0);
    chk("rst_stall", s_stall, 1'b0);
    chk("rst_wb_data", wb_data, 16'h0000);
    chk("rst_wb_reg", wb_reg, 3'd0);
    chk("rst_wb_flags", {wb_en, wb_halt, wb_err}, 3'b000);
    rst = 1'b1;

    // 1: load completing in the request cycle
    put(1'b1, mkpass(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 3'd3), 16'h0010, 16'h0000,
        16'h1111, 16'h0102, 1'b1, 16'hBEEF);
    tick();
    chk("t1_req", s_req, 1'b1);
    chk("t1_stall", s_stall, 1'b0);
    chk("t1_wb_data", wb_data, 16'hBEEF);
    chk("t1_wb_reg", wb_reg, 3'd3);
    chk("t1_wb_en", wb_en, 1'b1);

    // 2: store acknowledged after three stall cycles; reg_write is ignored
    put(1'b1, mkpass(1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 3'd5), 16'h0020, 16'h1234,
        16'h0000, 16'h0000, 1'b0, 16'h0000);
    n_st = 0;
    for (int i = 0; i < 4; i++) begin
      mem_done = (i == 3);
      tick();
      n_st += int'(s_stall);
    end
    chk("t2_stall_cycles", n_st, 3);
    chk("t2_wb_en", wb_en, 1'b0);
    chk("t2_wb_err", wb_err, 1'b0);

    // 3: ALU result passes through, no request
    put(1'b1, mkpass(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 3'd5), 16'h00A5, 16'h0000,
        16'h0000, 16'h0000, 1'b0, 16'h0000);
    tick();
    chk("t3_req", s_req, 1'b0);
    chk("t3_wb_data", wb_data, 16'h00A5);
    chk("t3_wb_en", wb_en, 1'b1);
    idle();
    tick();
    chk("hold_wb_data", wb_data, 16'h00A5);
    chk("hold_wb_en", wb_en, 1'b0);

    // other writeback selects, malformed St+Ld, and a one-wait load
    put(1'b1, mkpass(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 3'd1), 16'h0003, 16'h0000,
        16'h7777, 16'h0000, 1'b0, 16'h0000);
    tick();
    chk("imm_wb_data", wb_data, 16'h7777);
    put(1'b1, mkpass(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd2), 16'h0003, 16'h0000,
        16'h7777, 16'h0102, 1'b0, 16'h0000);
    tick();
    chk("pc2_wb_data", wb_data, 16'h0102);
    put(1'b1, mkpass(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 3'd6), 16'h0030, 16'h0000,
        16'h0000, 16'h0000, 1'b1, 16'h0000);
    tick();
    chk("both_req", s_req, 1'b0);
    chk("both_wb_err", wb_err, 1'b1);
    chk("both_wb_en", wb_en, 1'b0);
    put(1'b1, mkpass(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 3'd7), 16'h0032, 16'h0000,
        16'h0000, 16'h0000, 1'b0, 16'h0000);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h4242;
    tick();
    chk("ld1_wb_data", wb_data, 16'h4242);
    chk("ld1_wb_reg", wb_reg, 3'd7);

    // 4: load never acknowledged times out after MAX_WAIT wait cycles
    put(1'b1, mkpass(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 3'd4), 16'h0040, 16'h0000,
        16'h0000, 16'h0000, 1'b0, 16'h5555);
    n_req = 0; n_st = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_req += int'(s_req);
      n_st += int'(s_stall);
    end
    chk("t4_req_cycles", n_req, 5);
    chk("t4_stall_cycles", n_st, 4);
    chk("t4_wb_err", wb_err, 1'b1);
    chk("t4_wb_en", wb_en, 1'b0);
    idle();
    tick();
    chk("t4_req_after", s_req, 1'b0);

    // 6: reset while waiting abandons the access
    put(1'b1, mkpass(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0), 16'h0060, 16'hABCD,
        16'h0000, 16'h0000, 1'b0, 16'h0000);
    tick(); tick();
    chk("t6_req_wait", s_req, 1'b1);
    rst = 1'b0;
    tick();
    chk("t6_wb_data", wb_data, 16'h0000);
    chk("t6_wb_flags", {wb_en, wb_halt, wb_err}, 3'b000);
    rst = 1'b1;
    idle();
    tick();
    chk("t6_req_after", s_req, 1'b0);

    // 5: halt carrying Ld bit, then a store that must not reach memory
    put(1'b1, mkpass(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3'd0), 16'h0070, 16'h0000,
        16'h0000, 16'h0200, 1'b0, 16'h0000);
    tick();
    chk("t5_halt_req", s_req, 1'b0);
    chk("t5_wb_halt", wb_halt, 1'b1);
    put(1'b1, mkpass(1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 3'd2), 16'h0080, 16'h9999,
        16'h0000, 16'h0000, 1'b1, 16'h0000);
    tick();
    chk("t5_st_req", s_req, 1'b0);
    chk("t5_wb_halt2", wb_halt, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) tick();
    chk("t5_wb_halt3", wb_halt, 1'b1);
    chk("t5_wb_en", wb_en, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
